// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the I/D requesters, the arbiter and the unified memory.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_read_req;
    logic        d_write_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_en;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
    logic        m_ack;

    logic        err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_read_req, d_write_req, d_addr, d_wdata, d_byte_en,
        output d_rdata, d_done,
        output m_req, m_we, m_addr, m_wdata, m_byte_en,
        input  m_rdata, m_ack,
        output err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_read_req, d_write_req, d_addr, d_wdata, d_byte_en,
        input  d_rdata, d_done,
        input  m_req, m_we, m_addr, m_wdata, m_byte_en,
        output m_rdata, m_ack,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch (I) and load/store (D).
// D has fixed priority, bounded by a starvation limit; a timeout aborts a hung memory access.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.master  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam bit         TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TMO_LAST   = TMO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;

    logic d_any;
    logic grant_i;
    logic grant_d;
    logic in_gnt;
    logic tmo_hit;
    logic finish;
    logic i_fin;
    logic d_fin;

    always_comb begin
        d_any   = bus.d_read_req | bus.d_write_req;
        in_gnt  = (state_q != IDLE);
        grant_i = (state_q == IDLE) && bus.if_req && (!d_any || (starve_q == STARVE_MAX));
        grant_d = (state_q == IDLE) && !grant_i && d_any;
        // A same-cycle ack beats the timeout.
        tmo_hit = TMO_EN && in_gnt && !bus.m_ack && (tmo_q == TMO_LAST);
        finish  = in_gnt && (bus.m_ack || tmo_hit);
        i_fin   = finish && (state_q == GNT_I);
        d_fin   = finish && (state_q == GNT_D);
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q | tmo_hit;

        case (state_q)
            IDLE: begin
                tmo_d = 8'd0;
                if (grant_i) begin
                    state_d   = GNT_I;
                    starve_d  = 4'd0;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                    m_wdata_d = 32'h0;
                    m_be_d    = 4'hF;
                end else if (grant_d) begin
                    state_d   = GNT_D;
                    // Read and write together decode as a write.
                    m_we_d    = bus.d_write_req;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_be_d    = bus.d_byte_en;
                    if (!bus.if_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (!bus.if_req) begin
                    starve_d = 4'd0;
                end
            end
            GNT_I, GNT_D: begin
                if (tmo_q != 8'hFF) begin
                    tmo_d = tmo_q + 8'd1;
                end
                if (finish) begin
                    state_d = IDLE;
                end
                if (i_fin) begin
                    if_rdata_d = bus.m_ack ? bus.m_rdata : 32'h0;
                end
                if (d_fin) begin
                    if (!bus.m_ack) begin
                        d_rdata_d = 32'h0;
                    end else if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            tmo_q      <= 8'd0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            m_be_q     <= 4'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    // Read data is the next-state value, so it shows m_rdata in the completion cycle.
    assign bus.if_rdata  = if_rdata_d;
    assign bus.d_rdata   = d_rdata_d;
    assign bus.if_done   = i_fin;
    assign bus.d_done    = d_fin;
    assign bus.m_req     = in_gnt;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_byte_en = m_be_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus
// contention, timeout and mid-transaction reset sequences.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] if_model = 32'h0;
    logic [31:0] d_model  = 32'h0;

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic [31:0] mrd;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.if_req      = 1'b0;
        bus.d_read_req  = 1'b0;
        bus.d_write_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(posedge clk); #1;
        if (v.is_d) begin
            bus.d_read_req  = v.rd;
            bus.d_write_req = v.wr;
            bus.d_addr      = v.addr;
            bus.d_wdata     = v.wdata;
            bus.d_byte_en   = v.be;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
        n = 0;
        @(negedge clk);
        while (!bus.m_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_latency", idx), n, 1);
        for (int k = 0; k <= v.delay; k++) begin
            chk($sformatf("v%0d_c%0d_addr", idx, k), bus.m_addr, v.addr);
            chk($sformatf("v%0d_c%0d_ctl", idx, k), {26'b0, bus.m_req, bus.m_we, bus.m_byte_en},
                {26'b0, 1'b1, v.exp_we, v.exp_be});
            if (v.is_d) chk($sformatf("v%0d_c%0d_wdata", idx, k), bus.m_wdata, v.wdata);
            if (k == v.delay) break;
            chk($sformatf("v%0d_c%0d_nodone", idx, k), {30'b0, bus.if_done, bus.d_done}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = v.mrd;
        #1;
        chk($sformatf("v%0d_done", idx), {30'b0, bus.if_done, bus.d_done},
            v.is_d ? 32'h1 : 32'h2);
        if (v.is_d) begin
            chk($sformatf("v%0d_d_rdata", idx), bus.d_rdata, v.exp_rdata);
            chk($sformatf("v%0d_if_rdata_kept", idx), bus.if_rdata, if_model);
        end else begin
            chk($sformatf("v%0d_if_rdata", idx), bus.if_rdata, v.exp_rdata);
            chk($sformatf("v%0d_d_rdata_kept", idx), bus.d_rdata, d_model);
        end
        @(posedge clk); #1;
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'h0;
        drop_reqs();
        @(negedge clk);
        chk($sformatf("v%0d_after_req", idx), {30'b0, bus.m_req, bus.if_done | bus.d_done}, 32'h0);
        chk($sformatf("v%0d_rdata_held", idx), v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
        if (v.is_d) d_model = v.exp_rdata;
        else if_model = v.exp_rdata;
    endtask

    initial begin
        int          g;
        int          cyc;
        int          hi;
        int          done_at;
        logic        is_i;
        logic [9:0]  exp_i;

        rst             = 1'b1;
        bus.if_req      = 1'b0;
        bus.if_addr     = 32'h0;
        bus.d_read_req  = 1'b0;
        bus.d_write_req = 1'b0;
        bus.d_addr      = 32'h0;
        bus.d_wdata     = 32'h0;
        bus.d_byte_en   = 4'h0;
        bus.m_rdata     = 32'h0;
        bus.m_ack       = 1'b0;

        //            is_d  rd    wr    addr          wdata         be    dly mrd           we    be    exp_rdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 3, 32'h0050_0093, 1'b0, 4'hF, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'hF, 0, 32'h1234_5678, 1'b0, 4'hF, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_2004, 32'h0000_00A5, 4'h1, 2, 32'hDEAD_BEEF, 1'b1, 4'h1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hC, 1, 32'h1111_1111, 1'b1, 4'hC, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'hF, 0, 32'h0000_0013, 1'b0, 4'hF, 32'h0000_0013};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'h0,        4'hF, 7, 32'h7777_0007, 1'b0, 4'hF, 32'h7777_0007};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,        4'h3, 5, 32'h0BAD_F00D, 1'b0, 4'h3, 32'h0BAD_F00D};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {26'b0, bus.m_req, bus.m_we, bus.m_byte_en}, 32'h0);
        chk("rst_maddr", bus.m_addr, 32'h0);
        chk("rst_mwdata", bus.m_wdata, 32'h0);
        chk("rst_done_err", {29'b0, bus.if_done, bus.d_done, bus.err}, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("no_err_after_vectors", {31'b0, bus.err}, 32'h0);

        // Both requesters held, zero-wait memory: D x4 then a forced I, twice.
        exp_i = 10'h210;
        @(posedge clk); #1;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h0000_0500;
        bus.d_read_req = 1'b1;
        bus.d_addr     = 32'h0000_0600;
        bus.d_byte_en  = 4'hF;
        g   = 0;
        cyc = 0;
        while (g < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.m_req) begin
                is_i        = (bus.m_addr == 32'h0000_0500);
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h1000 + 32'(g);
                #1;
                chk($sformatf("grant%0d_is_i", g), {31'b0, is_i}, {31'b0, exp_i[g]});
                chk($sformatf("grant%0d_done", g), {31'b0, is_i ? bus.if_done : bus.d_done}, 32'h1);
                g++;
                @(posedge clk); #1;
                bus.m_ack = 1'b0;
            end
        end
        chk("contention_grants", g, 10);
        drop_reqs();
        @(negedge clk);
        chk("contention_if_rdata", bus.if_rdata, 32'h0000_1009);
        chk("contention_d_rdata", bus.d_rdata, 32'h0000_1008);

        // Memory never acks: abort after 8 request cycles.
        @(posedge clk); #1;
        bus.d_read_req = 1'b1;
        bus.d_addr     = 32'h0000_0700;
        hi      = 0;
        done_at = -1;
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            @(negedge clk);
            if (bus.m_req) hi++;
            if (bus.d_done) begin
                done_at = hi;
                chk("tmo_rdata", bus.d_rdata, 32'h0);
            end
        end
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        chk("tmo_mreq_cycles", hi, 8);
        chk("tmo_done_cycle", done_at, 8);
        chk("tmo_mreq_low", {31'b0, bus.m_req}, 32'h0);
        chk("tmo_err", {31'b0, bus.err}, 32'h1);
        chk("tmo_rdata_held", bus.d_rdata, 32'h0);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", {31'b0, bus.err}, 32'h1);

        // Reset while GNT_D, then a stray ack that must be ignored.
        @(posedge clk); #1;
        bus.d_read_req = 1'b1;
        bus.d_addr     = 32'h0000_0900;
        cyc = 0;
        @(negedge clk);
        while (!bus.m_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstop_granted", {31'b0, bus.m_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        drop_reqs();
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("rstop_no_done", {31'b0, bus.d_done}, 32'h0);
        chk("rstop_mreq", {31'b0, bus.m_req}, 32'h0);
        chk("rstop_err", {31'b0, bus.err}, 32'h0);
        chk("rstop_d_rdata", bus.d_rdata, 32'h0);
        chk("rstop_maddr", bus.m_addr, 32'h0);
        @(posedge clk); #1;
        bus.m_ack = 1'b0;
        @(negedge clk);
        chk("rstop_idle", {30'b0, bus.m_req, bus.d_done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
